// File: rtl/nim_match_ctrl.sv
// ============================================================================
// Module   : nim_match_ctrl
// Purpose  : Match-level controller for the Nim game. It launches rounds,
//            runs the per-turn countdown and awards round points. It ends
//            the match at WIN_SCORE and drives two BCD turn-time digits.
// Options  : NIM_TURN_TIMER_EN - compiles in the turn timer, the prescaler
//            and the timeout path. When undefined, rounds end only via
//            round_over_i and the digits are constant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nim_match_ctrl #(
  parameter int unsigned TICK_DIV     = 100_000_000,
  parameter int unsigned TURN_SECONDS = 15,
  parameter int unsigned WIN_SCORE    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       move_done_i,
  input  logic       round_over_i,
  input  logic       winner_i,
  input  logic       player_turn_i,
  output logic       game_start_o,
  output logic       inc_left_o,
  output logic       inc_right_o,
  output logic       timeout_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] sec_ones_o,
  output logic [3:0] score_left_o,
  output logic [3:0] score_right_o,
  output logic       match_over_o
);

  localparam logic [3:0] c_TENS = 4'(TURN_SECONDS / 10);
  localparam logic [3:0] c_ONES = 4'(TURN_SECONDS % 10);
  localparam logic [3:0] c_WIN  = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_PLAY   = 3'd2,
    S_AWARD  = 3'd3,
    S_CHECK  = 3'd4,
    S_BREAK  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t     state_q;
  logic       game_start_q;
  logic       inc_left_q;
  logic       inc_right_q;
  logic       match_over_q;
  logic       win_q;          // latched round winner, 1 = right
  logic [3:0] score_left_q;
  logic [3:0] score_right_q;

`ifdef NIM_TURN_TIMER_EN
  localparam int unsigned c_PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [c_PW-1:0] presc_q;
  logic [3:0]      tens_q;
  logic [3:0]      ones_q;
  logic            timeout_q;
  logic            tick_d;
  logic            timer_zero_d;
  logic [3:0]      tens_dec_d;
  logic [3:0]      ones_dec_d;

  // Tick detect and one-step BCD decrement of the turn timer
  always_comb begin
    tick_d       = (presc_q == c_PW'(TICK_DIV - 1));
    timer_zero_d = (tens_q == 4'd0) && (ones_q == 4'd0);
    if (ones_q == 4'd0) begin
      ones_dec_d = 4'd9;
      tens_dec_d = tens_q - 4'd1;
    end else begin
      ones_dec_d = ones_q - 4'd1;
      tens_dec_d = tens_q;
    end
  end
`endif

  // Match FSM with registered pulse outputs, scores and turn timer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      game_start_q  <= 1'b0;
      inc_left_q    <= 1'b0;
      inc_right_q   <= 1'b0;
      match_over_q  <= 1'b0;
      win_q         <= 1'b0;
      score_left_q  <= 4'd0;
      score_right_q <= 4'd0;
`ifdef NIM_TURN_TIMER_EN
      timeout_q     <= 1'b0;
      presc_q       <= '0;
      tens_q        <= c_TENS;
      ones_q        <= c_ONES;
`endif
    end else begin
      // Pulses last exactly one cycle unless re-asserted below
      game_start_q <= 1'b0;
      inc_left_q   <= 1'b0;
      inc_right_q  <= 1'b0;
`ifdef NIM_TURN_TIMER_EN
      timeout_q    <= 1'b0;
`endif
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q       <= S_LAUNCH;
            score_left_q  <= 4'd0;
            score_right_q <= 4'd0;
            match_over_q  <= 1'b0;
          end
        end
        S_BREAK: begin
          if (start_i) state_q <= S_LAUNCH;
        end
        S_LAUNCH: begin
          game_start_q <= 1'b1;
          state_q      <= S_PLAY;
`ifdef NIM_TURN_TIMER_EN
          tens_q       <= c_TENS;
          ones_q       <= c_ONES;
          presc_q      <= '0;
`endif
        end
        S_PLAY: begin
          // A finished round beats both a move commit and a timeout
          if (round_over_i) begin
            win_q   <= winner_i;
            state_q <= S_AWARD;
          end
`ifdef NIM_TURN_TIMER_EN
          else if (move_done_i) begin
            tens_q  <= c_TENS;
            ones_q  <= c_ONES;
            presc_q <= '0;
          end else if (tick_d) begin
            presc_q <= '0;
            if (timer_zero_d) begin
              // The player who ran out of time loses the round
              win_q     <= ~player_turn_i;
              timeout_q <= 1'b1;
              state_q   <= S_AWARD;
            end else begin
              tens_q <= tens_dec_d;
              ones_q <= ones_dec_d;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
`endif
        end
        S_AWARD: begin
          if (win_q) begin
            inc_right_q <= 1'b1;
            if (score_right_q < c_WIN) score_right_q <= score_right_q + 4'd1;
          end else begin
            inc_left_q <= 1'b1;
            if (score_left_q < c_WIN) score_left_q <= score_left_q + 4'd1;
          end
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          if ((win_q ? score_right_q : score_left_q) == c_WIN) begin
            state_q      <= S_DONE;
            match_over_q <= 1'b1;
          end else begin
            state_q <= S_BREAK;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign game_start_o  = game_start_q;
  assign inc_left_o    = inc_left_q;
  assign inc_right_o   = inc_right_q;
  assign match_over_o  = match_over_q;
  assign score_left_o  = score_left_q;
  assign score_right_o = score_right_q;

`ifdef NIM_TURN_TIMER_EN
  assign timeout_o  = timeout_q;
  assign sec_tens_o = tens_q;
  assign sec_ones_o = ones_q;
`else
  assign timeout_o  = 1'b0;
  assign sec_tens_o = c_TENS;
  assign sec_ones_o = c_ONES;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nim_match_ctrl.sv
// ============================================================================
// Module   : tb_nim_match_ctrl
// Purpose  : Self-checking bench for nim_match_ctrl with TICK_DIV=4,
//            TURN_SECONDS=3, WIN_SCORE=2. Adapts to NIM_TURN_TIMER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nim_match_ctrl;

  localparam int TD = 4;
  localparam int TS = 3;
  localparam int WS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st = 1'b0, md = 1'b0, ro = 1'b0, wn = 1'b0, pt = 1'b0;
  logic gs, il, ir, to, mo;
  logic [3:0] tens, ones, sl, sr;

  int total = 0;
  int bad   = 0;

  nim_match_ctrl #(.TICK_DIV(TD), .TURN_SECONDS(TS), .WIN_SCORE(WS)) dut (
    .clk(clk), .reset(rst), .start_i(st), .move_done_i(md),
    .round_over_i(ro), .winner_i(wn), .player_turn_i(pt),
    .game_start_o(gs), .inc_left_o(il), .inc_right_o(ir), .timeout_o(to),
    .sec_tens_o(tens), .sec_ones_o(ones), .score_left_o(sl),
    .score_right_o(sr), .match_over_o(mo)
  );

  always #5 clk = ~clk;

  // Output vector layout: {gs, il, ir, to, mo, sl, sr, tens, ones}
  function automatic logic [20:0] pk(bit g, bit l, bit r, bit t, bit m,
                                     int ssl, int ssr, int secs);
    logic [3:0] a, b, c, d;
    a = 4'(ssl); b = 4'(ssr); c = 4'(secs / 10); d = 4'(secs % 10);
    return {g, l, r, t, m, a, b, c, d};
  endfunction

  logic [20:0] dut_vec;
  assign dut_vec = {gs, il, ir, to, mo, sl, sr, tens, ones};

  task automatic check(string name, logic [20:0] got, logic [20:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (gs,il,ir,to,mo,sl,sr,tens,ones)", name, got, exp);
    end
  endtask

  task automatic check1(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // ---------------- behavioural reference model (event schedule) ----------
  int cyc = 0;
  bit m_playing = 0, m_can_start = 1, m_w = 0;
  int m_launch_at = -1, m_award_at = -1, m_check_at = -1, m_turn_start = 0;
  int m_sl = 0, m_sr = 0, m_secs = TS;
  bit m_gs = 0, m_il = 0, m_ir = 0, m_to = 0, m_mo = 0;

  task automatic model_update();
    int e;
    cyc++;
    m_gs = 0; m_il = 0; m_ir = 0; m_to = 0;
    if (rst) begin
      m_playing = 0; m_can_start = 1; m_w = 0;
      m_launch_at = -1; m_award_at = -1; m_check_at = -1;
      m_sl = 0; m_sr = 0; m_mo = 0; m_secs = TS;
    end else if (m_launch_at == cyc) begin
      m_gs = 1; m_secs = TS; m_turn_start = cyc; m_playing = 1;
    end else if (m_playing) begin
      if (ro) begin
        m_w = wn; m_playing = 0; m_award_at = cyc + 1;
      end
`ifdef NIM_TURN_TIMER_EN
      else if (md) begin
        m_turn_start = cyc; m_secs = TS;
      end else begin
        e = cyc - m_turn_start;
        if (e > 0 && e % TD == 0) begin
          if (e / TD > TS) begin
            m_to = 1; m_w = !pt; m_playing = 0; m_award_at = cyc + 1;
          end else begin
            m_secs = TS - e / TD;
          end
        end
      end
`endif
    end else if (m_award_at == cyc) begin
      if (m_w) begin m_ir = 1; m_sr++; end
      else begin m_il = 1; m_sl++; end
      m_check_at = cyc + 1;
    end else if (m_check_at == cyc) begin
      if ((m_w ? m_sr : m_sl) == WS) m_mo = 1;
      m_can_start = 1;
    end else if (m_can_start && st) begin
      if (m_mo) begin m_sl = 0; m_sr = 0; m_mo = 0; end
      m_can_start = 0; m_launch_at = cyc + 1;
    end
  endtask

  // One clock: model samples the same inputs as the DUT, outputs read #1 later
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clr_in();
    st = 0; md = 0; ro = 0; wn = 0; pt = 0;
  endtask

  task automatic do_reset();
    clr_in(); rst = 1; step(); rst = 0;
  endtask

  // start pulse; returns just after the edge where game_start is visible
  task automatic launch();
    st = 1; step(); st = 0; step();
  endtask

  typedef struct {
    logic r, s, m, o, w, p;
    logic [20:0] exp;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // Directed table: reset, right win, BREAK, match won, restart from DONE
    tbl[0]  = '{1,0,0,0,0,0, pk(0,0,0,0,0,0,0,TS)};
    tbl[1]  = '{0,0,0,0,0,0, pk(0,0,0,0,0,0,0,TS)};
    tbl[2]  = '{0,1,0,0,0,0, pk(0,0,0,0,0,0,0,TS)};
    tbl[3]  = '{0,0,0,0,0,0, pk(1,0,0,0,0,0,0,TS)};
    tbl[4]  = '{0,1,0,0,0,0, pk(0,0,0,0,0,0,0,TS)};
    tbl[5]  = '{0,0,0,1,1,0, pk(0,0,0,0,0,0,0,TS)};
    tbl[6]  = '{0,0,0,0,0,0, pk(0,0,1,0,0,0,1,TS)};
    tbl[7]  = '{0,0,0,0,0,0, pk(0,0,0,0,0,0,1,TS)};
    tbl[8]  = '{0,0,1,1,0,0, pk(0,0,0,0,0,0,1,TS)};
    tbl[9]  = '{0,1,0,0,0,0, pk(0,0,0,0,0,0,1,TS)};
    tbl[10] = '{0,0,0,0,0,0, pk(1,0,0,0,0,0,1,TS)};
    tbl[11] = '{0,0,0,1,1,0, pk(0,0,0,0,0,0,1,TS)};
    tbl[12] = '{0,0,0,0,0,0, pk(0,0,1,0,0,0,2,TS)};
    tbl[13] = '{0,0,0,0,0,0, pk(0,0,0,0,1,0,2,TS)};
    tbl[14] = '{0,1,0,0,0,0, pk(0,0,0,0,0,0,0,TS)};
    tbl[15] = '{0,0,0,0,0,0, pk(1,0,0,0,0,0,0,TS)};

    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].r; st = tbl[i].s; md = tbl[i].m;
      ro = tbl[i].o; wn = tbl[i].w; pt = tbl[i].p;
      step();
      check($sformatf("table[%0d]", i), dut_vec, tbl[i].exp);
    end
    clr_in();

    // Turn countdown and timeout with no moves, left to move
    do_reset(); launch();
`ifdef NIM_TURN_TIMER_EN
    for (int e = 1; e <= 15; e++) begin
      step();
      check($sformatf("countdown e=%0d", e), dut_vec, pk(0,0,0,0,0,0,0,TS - e / TD));
    end
    step();
    check("timeout pulse", dut_vec, pk(0,0,0,1,0,0,0,0));
    step();
    check("timeout award right", dut_vec, pk(0,0,1,0,0,0,1,0));
`else
    for (int e = 1; e <= 100; e++) begin
      step();
      check($sformatf("no timer e=%0d", e), dut_vec, pk(0,0,0,0,0,0,0,TS));
    end
`endif

    // move_done reloads the digits and restarts the prescaler
    do_reset(); launch();
    for (int e = 1; e <= 8; e++) step();
`ifdef NIM_TURN_TIMER_EN
    check("digits before move", dut_vec, pk(0,0,0,0,0,0,0,1));
`else
    check("digits before move", dut_vec, pk(0,0,0,0,0,0,0,TS));
`endif
    md = 1; step(); md = 0;
    check("reload on move", dut_vec, pk(0,0,0,0,0,0,0,TS));
    for (int e = 1; e <= 3; e++) step();
    check("no tick 3 after move", dut_vec, pk(0,0,0,0,0,0,0,TS));
    step();
`ifdef NIM_TURN_TIMER_EN
    check("tick 4 after move", dut_vec, pk(0,0,0,0,0,0,0,TS - 1));
`else
    check("tick 4 after move", dut_vec, pk(0,0,0,0,0,0,0,TS));
`endif

    // round_over coinciding with the expiring tick: only the round winner scores
    do_reset(); launch();
    for (int e = 1; e <= 15; e++) step();
    ro = 1; wn = 0; pt = 0; step(); ro = 0;
    check1("no timeout on round_over", to, 0);
    step();
    check1("inc_left on round_over", il, 1);
    check1("inc_right stays low", ir, 0);
    check1("score_left one", sl, 1);
    step();
    st = 1; step(); st = 0; step();
    check1("game_start in round 2", gs, 1);
    ro = 1; wn = 0; step(); ro = 0; step();
    check1("score_left two", sl, 2);
    step();
    check1("match_over after two left wins", mo, 1);

    // reset during AWARD kills the pending increment
    do_reset(); launch();
    ro = 1; wn = 0; step(); ro = 0;
    rst = 1; step(); rst = 0;
    check("reset in AWARD", dut_vec, pk(0,0,0,0,0,0,0,TS));
    step();
    check("quiet after reset", dut_vec, pk(0,0,0,0,0,0,0,TS));
    st = 1; step(); st = 0; step();
    check1("restart after reset", gs, 1);

    // Randomized run against the reference model
    do_reset();
    check("random start", dut_vec, pk(m_gs,m_il,m_ir,m_to,m_mo,m_sl,m_sr,m_secs));
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      st  = ($urandom_range(0, 5) == 0);
      md  = ($urandom_range(0, 24) == 0);
      ro  = ($urandom_range(0, 39) == 0);
      wn  = 1'($urandom_range(0, 1));
      pt  = 1'($urandom_range(0, 1));
      step();
      check($sformatf("random cycle %0d", n), dut_vec,
            pk(m_gs,m_il,m_ir,m_to,m_mo,m_sl,m_sr,m_secs));
      check1($sformatf("inc exclusive %0d", n), int'(il & ir), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
